// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the pipeline hazard sequencer: sequencer state
//   encoding, default parameter values and a width helper.
//   Optional feature macro used by the top: HAZARD_PERF_EN.
package hazard_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALTED   = 3'd4
    } state_e;

    localparam int unsigned FLUSH_CYCLES_DEF = 2;
    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam int unsigned MEM_TIMEOUT_DEF  = 255;
    localparam int unsigned CNT_W_DEF        = 16;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk      in   1      clock
//     rst_n    in   1      asynchronous active-low reset (count -> 0)
//     i_inc    in   1      increment this cycle (ignored once saturated)
//     i_clr    in   1      synchronous clear, wins over i_inc
//     o_count  out  WIDTH  current count
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencer for the 5-stage CPU. Combines the load-use stall, the
//   EX branch-taken flag, memory busy flags and decoded halt into PC write
//   enable plus per-latch stall/flush controls. Owns memory-wait, branch
//   flush and halt-drain sequencing. Outputs are Mealy (state + inputs).
//   Optional feature macro: HAZARD_PERF_EN adds stallCycles/flushCount.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     forwardStall        load-use hazard from the forwarding unit
//     branchTaken         taken branch/jump resolved in EX
//     dMemBusy, iMemBusy  data access in progress / fetch not yet valid
//     halt_ID             HLT decoded in ID
//     pcWe                PC write enable
//     stall_*             hold the named pipeline latch
//     flush_IF_ID         load NOP into IF/ID
//     flush_ID_EX         load bubble into ID/EX
//     halted              pipeline drained and frozen
//     memTimeout          sticky data-memory watchdog flag
//     stallCycles         [HAZARD_PERF_EN] cycles with pcWe=0
//     flushCount          [HAZARD_PERF_EN] taken branches acted on
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF
`ifdef HAZARD_PERF_EN
    ,
    parameter int unsigned CNT_W        = CNT_W_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             forwardStall,
    input  logic             branchTaken,
    input  logic             dMemBusy,
    input  logic             iMemBusy,
    input  logic             halt_ID,
    output logic             pcWe,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             stall_EX_MEM,
    output logic             stall_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             halted,
    output logic             memTimeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
`endif
);

    localparam int unsigned SEQ_MAX = (FLUSH_CYCLES > DRAIN_CYCLES) ? FLUSH_CYCLES : DRAIN_CYCLES;
    localparam int unsigned SEQ_W   = width_for(SEQ_MAX);
    localparam int unsigned WAIT_W  = width_for(MEM_TIMEOUT);

    localparam logic [SEQ_W-1:0]  FLUSH_RELOAD = SEQ_W'(FLUSH_CYCLES - 1);
    localparam logic [SEQ_W-1:0]  DRAIN_RELOAD = SEQ_W'(DRAIN_CYCLES);
    localparam logic [SEQ_W-1:0]  SEQ_ONE      = SEQ_W'(1);
    localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam bit                MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_e             r_state, w_next_state;
    state_e             r_resume, w_next_resume;
    state_e             w_eff_state;
    logic [SEQ_W-1:0]   r_cnt, w_next_cnt;
    logic               r_memTimeout, w_next_memTimeout;
    logic [WAIT_W-1:0]  w_wait_cnt;
    logic               w_wait_inc;
    logic               w_wait_clr;
    logic               w_take_branch;

    // On the cycle dMemBusy falls the saved state acts immediately, so a
    // frozen FLUSH/DRAIN sequence picks up exactly where it stopped.
    assign w_eff_state   = (r_state == ST_MEM_WAIT) ? r_resume : r_state;
    assign w_take_branch = branchTaken && !dMemBusy && (r_state != ST_HALTED);

    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_wait_inc),
        .i_clr   (w_wait_clr),
        .o_count (w_wait_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_resume     <= ST_RUN;
            r_cnt        <= '0;
            r_memTimeout <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_resume     <= w_next_resume;
            r_cnt        <= w_next_cnt;
            r_memTimeout <= w_next_memTimeout;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state      = r_state;
        w_next_resume     = r_resume;
        w_next_cnt        = r_cnt;
        w_next_memTimeout = r_memTimeout;
        w_wait_inc        = 1'b0;
        w_wait_clr        = 1'b0;

        if (r_state != ST_HALTED) begin
            if (dMemBusy) begin
                w_next_state = ST_MEM_WAIT;
                if (r_state != ST_MEM_WAIT) begin
                    w_next_resume = r_state;
                end
                w_wait_inc = 1'b1;
                if ((MEM_TIMEOUT != 0) && (w_wait_cnt == TIMEOUT_LAST)) begin
                    w_next_memTimeout = 1'b1;
                end
            end else begin
                if (r_state == ST_MEM_WAIT) begin
                    w_wait_clr = 1'b1;
                end
                w_next_state = w_eff_state;
                if (w_take_branch) begin
                    if (MULTI_FLUSH) begin
                        w_next_state = ST_FLUSH;
                        w_next_cnt   = FLUSH_RELOAD;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end else begin
                    case (w_eff_state)
                        ST_RUN: begin
                            if (!forwardStall && halt_ID) begin
                                w_next_state = ST_DRAIN;
                                w_next_cnt   = DRAIN_RELOAD;
                            end
                        end
                        ST_FLUSH: begin
                            if (r_cnt <= SEQ_ONE) w_next_state = ST_RUN;
                            if (r_cnt != '0)      w_next_cnt   = r_cnt - SEQ_ONE;
                        end
                        ST_DRAIN: begin
                            if (r_cnt <= SEQ_ONE) w_next_state = ST_HALTED;
                            if (r_cnt != '0)      w_next_cnt   = r_cnt - SEQ_ONE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Output logic
    always_comb begin
        pcWe         = 1'b1;
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        stall_MEM_WB = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        halted       = 1'b0;

        if (r_state == ST_HALTED) begin
            halted       = 1'b1;
            pcWe         = 1'b0;
            stall_IF_ID  = 1'b1;
            stall_ID_EX  = 1'b1;
            stall_EX_MEM = 1'b1;
            stall_MEM_WB = 1'b1;
        end else if (dMemBusy) begin
            pcWe         = 1'b0;
            stall_IF_ID  = 1'b1;
            stall_ID_EX  = 1'b1;
            stall_EX_MEM = 1'b1;
            stall_MEM_WB = 1'b1;
        end else if (branchTaken) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
        end else begin
            case (w_eff_state)
                ST_RUN: begin
                    if (forwardStall) begin
                        pcWe        = 1'b0;
                        stall_IF_ID = 1'b1;
                        flush_ID_EX = 1'b1;
                    end else if (halt_ID) begin
                        pcWe        = 1'b0;
                        stall_IF_ID = 1'b1;
                    end else if (iMemBusy) begin
                        pcWe        = 1'b0;
                        flush_IF_ID = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush_IF_ID = 1'b1;
                end
                ST_DRAIN: begin
                    pcWe        = 1'b0;
                    stall_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign memTimeout = r_memTimeout;

`ifdef HAZARD_PERF_EN
    logic w_perf_live;
    assign w_perf_live = (r_state != ST_HALTED);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_perf_live && !pcWe),
        .i_clr   (1'b0),
        .o_count (stallCycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_take_branch),
        .i_clr   (1'b0),
        .o_count (flushCount)
    );
`endif

endmodule
